ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 10000, SHALL set the clock-inhibit hold length in clk cycles (100 us at 100 MHz).
REQ-002 Parameter START_TIMEOUT_CYCLES, default 1500000, SHALL set the maximum wait in clk cycles for the first device falling edge (15 ms).
REQ-003 Parameter PACKET_TIMEOUT_CYCLES, default 200000, SHALL set the maximum clk cycles from the first device falling edge to the ACK sample (2 ms).
REQ-004 Ports SHALL be, one per line (name, direction, width, meaning):
 clk  in  1  system clock (100 MHz); one clock only; the block is fully synchronous to it
 rst  in  1  synchronous reset, active-high
 tx_data  in  8  command byte to send to the PS/2 device
 tx_valid  in  1  request to send tx_data
 tx_ready  out  1  block idle, request acceptable
 ps2_clk_in  in  1  raw PS2_CLK pad input (asynchronous)
 ps2_data_in  in  1  raw PS2_DATA pad input (asynchronous)
 ps2_clk_oe  out  1  1 = drive PS2_CLK low; 0 = release
 ps2_data_oe  out  1  1 = drive PS2_DATA low; 0 = release
 busy  out  1  transfer in progress; the top level gates the keyboard receiver with it
 tx_done  out  1  one-cycle pulse: transfer finished (ACK sampled, lines idle)
 tx_ack_err  out  1  valid with tx_done: 1 = device did not ACK
 tx_timeout  out  1  one-cycle pulse: transfer aborted on a timeout

Function
REQ-005 ps2_clk_in and ps2_data_in SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be sync clock 1 on the previous cycle and 0 on the current cycle.
REQ-006 All outputs SHALL be registered.
REQ-007 States SHALL be IDLE, INHIBIT, REQ, START, BITS, ACK, WAIT_IDLE.
REQ-008 IDLE: tx_ready=1, busy=0, both oe=0. A transfer is accepted on tx_valid&&tx_ready; tx_data is latched; the next state is INHIBIT.
REQ-009 INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles; then REQ.
REQ-010 REQ: clk_oe=1, data_oe=1 (start bit) for 1 cycle; then START.
REQ-011 START: clk_oe=0, data_oe=1. The start-timeout counter runs. The first falling edge SHALL drive data bit 0, start the packet counter and enter BITS.
REQ-012 BITS: each subsequent falling edge SHALL advance one bit: data bits 1-7 LSB first, then the odd-parity bit (1 when tx_data has an even count of ones), then the stop bit. For each bit, data_oe = ~bit; for stop, data_oe=0. The stop bit goes out on falling edge 10; the block then enters ACK.
REQ-013 ACK: on falling edge 11, ps2_data sync SHALL be sampled; 0 = ACK, so tx_ack_err=0; 1 = no ACK, so tx_ack_err=1. Then WAIT_IDLE.
REQ-014 WAIT_IDLE: remain until both sync lines are 1; then pulse tx_done for 1 cycle with tx_ack_err and return to IDLE. tx_ack_err SHALL hold its value until the next accept.
REQ-015 Timeouts: if the start counter reaches START_TIMEOUT_CYCLES in START, or the packet counter reaches PACKET_TIMEOUT_CYCLES before the ACK sample, then:
 both oe SHALL be 0 on the next cycle
 tx_timeout SHALL pulse 1 cycle
 tx_done SHALL stay 0
 the state SHALL return to IDLE
REQ-016 busy SHALL be 1 in every state except IDLE. tx_valid while busy SHALL be ignored, and tx_data changes after accept SHALL have no effect.
REQ-017 tx_done and tx_timeout SHALL never assert in the same cycle.
REQ-018 Counters SHALL be sized by $clog2 of their parameter and SHALL NOT wrap.
REQ-019 Falling edges seen in IDLE, INHIBIT or REQ SHALL be ignored.
REQ-020 Total latency SHALL be accept -> INHIBIT_CYCLES+1 cycles -> device-clocked bits -> tx_done 1 cycle after idle lines are detected.

Reset
REQ-021 On rst=1 at a clk edge, the next cycle SHALL show:
 state IDLE
 ps2_clk_oe=0, ps2_data_oe=0
 tx_ready=1
 busy=0, tx_done=0, tx_ack_err=0, tx_timeout=0
 counters and shift register cleared
REQ-022 Reset mid-transfer SHALL release both lines with no tx_done or tx_timeout pulse.

Verification
REQ-023 Send 0xED, device model clocks and ACKs -> clk_oe=1 for INHIBIT_CYCLES, then start bit, then data_oe pattern ~{1,0,1,1,0,1,1,1}, parity 1, stop released -> tx_done=1, tx_ack_err=0.
REQ-024 Send 0xFF, device holds DATA high at edge 11 -> parity bit 1 -> tx_done=1, tx_ack_err=1.
REQ-025 Send 0x01, device never clocks, START_TIMEOUT_CYCLES=50 -> tx_timeout after 50 cycles in START, both oe=0, tx_ready=1, no tx_done.
REQ-026 Device stops clocking after edge 4, PACKET_TIMEOUT_CYCLES=200 -> tx_timeout, lines released.
REQ-027 rst=1 during BITS (after edge 5) -> next cycle both oe=0, tx_ready=1, busy=0, no pulses. A following 0x00 send completes with parity 1.
REQ-028 tx_valid with 0xAA asserted while busy -> ignored, and the in-flight byte is unchanged on the line.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus clock, issues a
// request-to-send, then shifts a byte plus odd parity and stop out on device clock edges.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES        = 10000,
  parameter int START_TIMEOUT_CYCLES  = 1500000,
  parameter int PACKET_TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack_err,
  output logic       tx_timeout
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int STO_W = $clog2(START_TIMEOUT_CYCLES + 1);
  localparam int PTO_W = $clog2(PACKET_TIMEOUT_CYCLES + 1);

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [STO_W-1:0] STO_LAST = STO_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [PTO_W-1:0] PTO_LAST = PTO_W'(PACKET_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_BIT_EDGE = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_START,
    S_BITS,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic r_clkMeta;
  logic r_clkSync;
  logic r_clkSyncD;
  logic r_dataMeta;
  logic r_dataSync;
  logic w_fall;

  logic [9:0]       r_shift;
  logic [9:0]       w_shiftNext;
  logic [3:0]       r_bitCnt;
  logic [3:0]       w_bitCntNext;
  logic [INH_W-1:0] r_inhCnt;
  logic [INH_W-1:0] w_inhCntNext;
  logic [STO_W-1:0] r_startCnt;
  logic [STO_W-1:0] w_startCntNext;
  logic [PTO_W-1:0] r_pktCnt;
  logic [PTO_W-1:0] w_pktCntNext;

  logic r_clkOe;
  logic r_dataOe;
  logic r_txReady;
  logic r_busy;
  logic r_txDone;
  logic r_ackErr;
  logic r_timeout;
  logic w_clkOeNext;
  logic w_dataOeNext;
  logic w_txReadyNext;
  logic w_busyNext;
  logic w_txDoneNext;
  logic w_ackErrNext;
  logic w_timeoutNext;

  // Synchronizers reset high so the idle bus never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clkMeta  <= 1'b1;
      r_clkSync  <= 1'b1;
      r_clkSyncD <= 1'b1;
      r_dataMeta <= 1'b1;
      r_dataSync <= 1'b1;
    end else begin
      r_clkMeta  <= ps2_clk_in;
      r_clkSync  <= r_clkMeta;
      r_clkSyncD <= r_clkSync;
      r_dataMeta <= ps2_data_in;
      r_dataSync <= r_dataMeta;
    end
  end

  assign w_fall = r_clkSyncD & ~r_clkSync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bitCnt   <= '0;
      r_inhCnt   <= '0;
      r_startCnt <= '0;
      r_pktCnt   <= '0;
      r_clkOe    <= 1'b0;
      r_dataOe   <= 1'b0;
      r_txReady  <= 1'b1;
      r_busy     <= 1'b0;
      r_txDone   <= 1'b0;
      r_ackErr   <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_shift    <= w_shiftNext;
      r_bitCnt   <= w_bitCntNext;
      r_inhCnt   <= w_inhCntNext;
      r_startCnt <= w_startCntNext;
      r_pktCnt   <= w_pktCntNext;
      r_clkOe    <= w_clkOeNext;
      r_dataOe   <= w_dataOeNext;
      r_txReady  <= w_txReadyNext;
      r_busy     <= w_busyNext;
      r_txDone   <= w_txDoneNext;
      r_ackErr   <= w_ackErrNext;
      r_timeout  <= w_timeoutNext;
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_shiftNext    = r_shift;
    w_bitCntNext   = r_bitCnt;
    w_inhCntNext   = r_inhCnt;
    w_startCntNext = r_startCnt;
    w_pktCntNext   = r_pktCnt;
    w_dataOeNext   = r_dataOe;
    w_ackErrNext   = r_ackErr;
    w_txDoneNext   = 1'b0;
    w_timeoutNext  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (tx_valid && r_txReady) begin
          // Frame is {stop, odd parity, data}; bit 0 goes out first.
          w_shiftNext  = {1'b1, ~^tx_data, tx_data};
          w_ackErrNext = 1'b0;
          w_inhCntNext = '0;
          w_bitCntNext = '0;
          w_stateNext  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (r_inhCnt == INH_LAST) begin
          w_stateNext = S_REQ;
        end else begin
          w_inhCntNext = r_inhCnt + 1'b1;
        end
      end
      S_REQ: begin
        w_startCntNext = '0;
        w_stateNext    = S_START;
      end
      S_START: begin
        if (w_fall) begin
          w_dataOeNext = ~r_shift[0];
          w_shiftNext  = {1'b0, r_shift[9:1]};
          w_bitCntNext = 4'd1;
          w_pktCntNext = '0;
          w_stateNext  = S_BITS;
        end else if (r_startCnt == STO_LAST) begin
          w_timeoutNext = 1'b1;
          w_stateNext   = S_IDLE;
        end else begin
          w_startCntNext = r_startCnt + 1'b1;
        end
      end
      S_BITS: begin
        if (r_pktCnt == PTO_LAST) begin
          w_timeoutNext = 1'b1;
          w_stateNext   = S_IDLE;
        end else begin
          w_pktCntNext = r_pktCnt + 1'b1;
          if (w_fall) begin
            w_dataOeNext = ~r_shift[0];
            w_shiftNext  = {1'b0, r_shift[9:1]};
            w_bitCntNext = r_bitCnt + 1'b1;
            if (r_bitCnt == LAST_BIT_EDGE) begin
              w_stateNext = S_ACK;
            end
          end
        end
      end
      S_ACK: begin
        // An ACK edge arriving on the final counted cycle still wins over the timeout.
        if (w_fall) begin
          w_ackErrNext = r_dataSync;
          w_stateNext  = S_WAIT_IDLE;
        end else if (r_pktCnt == PTO_LAST) begin
          w_timeoutNext = 1'b1;
          w_stateNext   = S_IDLE;
        end else begin
          w_pktCntNext = r_pktCnt + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (r_clkSync && r_dataSync) begin
          w_txDoneNext = 1'b1;
          w_stateNext  = S_IDLE;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase

    // Line drives follow the state being entered so they line up with it.
    w_clkOeNext   = (w_stateNext == S_INHIBIT) || (w_stateNext == S_REQ);
    w_txReadyNext = (w_stateNext == S_IDLE);
    w_busyNext    = (w_stateNext != S_IDLE);
    if ((w_stateNext == S_REQ) || (w_stateNext == S_START)) begin
      w_dataOeNext = 1'b1;
    end else if (w_stateNext != S_BITS) begin
      w_dataOeNext = 1'b0;
    end
  end

  assign tx_ready    = r_txReady;
  assign ps2_clk_oe  = r_clkOe;
  assign ps2_data_oe = r_dataOe;
  assign busy        = r_busy;
  assign tx_done     = r_txDone;
  assign tx_ack_err  = r_ackErr;
  assign tx_timeout  = r_timeout;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: an open-drain bus with a simple device model,
// and a scoreboard of expected frames checked when each transfer completes.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int STO  = 50;
  localparam int PTO  = 200;
  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_ack_err;
  logic       tx_timeout;

  logic devClkLow;
  logic devDataLow;

  typedef struct {
    logic [9:0] frame;
    logic       ackErr;
  } exp_t;

  exp_t       sbQ[$];
  logic [9:0] capFrame;
  int         passCount  = 0;
  int         checkCount = 0;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT_CYCLES(STO),
    .PACKET_TIMEOUT_CYCLES(PTO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy(busy),
    .tx_done(tx_done),
    .tx_ack_err(tx_ack_err),
    .tx_timeout(tx_timeout)
  );

  always #5 clk = ~clk;

  // Wired-AND bus: either side pulling low wins.
  assign ps2_clk_in  = ~(ps2_clk_oe | devClkLow);
  assign ps2_data_in = ~(ps2_data_oe | devDataLow);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Expected line frame {stop, parity, data}, parity set when the data has an even count of ones.
  function automatic logic [9:0] expFrame(input logic [7:0] d);
    int   ones = 0;
    logic par;
    for (int i = 0; i < 8; i++) begin
      if (d[i]) ones++;
    end
    par = (ones % 2 == 0);
    return {1'b1, par, d};
  endfunction

  // Accepts a byte, then checks the inhibit length, request cycle and start state.
  task automatic applyStimulus(input string tag, input logic [7:0] data, input logic holdAa);
    int inhCount = 0;
    @(negedge clk);
    checkOutput({tag, "_readyIdle"}, 32'(tx_ready), 32'd1);
    tx_data  = data;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = holdAa;
    tx_data  = 8'hAA;
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < 1000; i++) begin
      if (ps2_clk_oe && !ps2_data_oe) begin
        inhCount++;
        @(negedge clk);
      end else begin
        break;
      end
    end
    checkOutput({tag, "_inhibitLen"}, 32'(inhCount), 32'(INH));
    checkOutput({tag, "_reqOe"}, 32'({ps2_clk_oe, ps2_data_oe}), 32'd3);
    @(negedge clk);
    checkOutput({tag, "_startOeReady"}, 32'({ps2_clk_oe, ps2_data_oe, tx_ready}), 32'b010);
  endtask

  // Device model: clocks nEdges falling edges, capturing the line late in each low phase.
  task automatic deviceClock(input int nEdges, input logic ack);
    capFrame = '0;
    repeat (3) @(negedge clk);
    for (int k = 1; k <= nEdges; k++) begin
      if (k == 11) devDataLow = ack;
      repeat (HALF) @(negedge clk);
      devClkLow = 1'b1;
      repeat (HALF) @(negedge clk);
      if (k <= 10) capFrame[k-1] = ps2_data_in;
      devClkLow = 1'b0;
    end
    devDataLow = 1'b0;
    tx_valid   = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    exp_t e;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_done || tx_timeout) break;
    end
    checkOutput({tag, "_done"}, 32'(tx_done), 32'd1);
    checkOutput({tag, "_noTimeout"}, 32'(tx_timeout), 32'd0);
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
    end else begin
      e.frame  = 'x;
      e.ackErr = 1'bx;
    end
    checkOutput({tag, "_frame"}, 32'(capFrame), 32'(e.frame));
    checkOutput({tag, "_ackErr"}, 32'(tx_ack_err), 32'(e.ackErr));
    @(negedge clk);
    checkOutput({tag, "_donePulse"}, 32'(tx_done), 32'd0);
    checkOutput({tag, "_ackErrHeld"}, 32'(tx_ack_err), 32'(e.ackErr));
    checkOutput({tag, "_idleAfter"}, 32'({tx_ready, busy}), 32'b10);
  endtask

  // Waits for a timeout pulse; expStart >= 0 also checks the cycles spent in START.
  task automatic waitTimeout(input string tag, input int expStart);
    int   startCycles = 0;
    logic sawDone = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (tx_timeout) break;
      if (tx_done) sawDone = 1'b1;
      if (!ps2_clk_oe && ps2_data_oe && busy) startCycles++;
      @(negedge clk);
    end
    checkOutput({tag, "_timeout"}, 32'(tx_timeout), 32'd1);
    if (expStart >= 0) checkOutput({tag, "_startCycles"}, 32'(startCycles), 32'(expStart));
    checkOutput({tag, "_linesReleased"}, 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    checkOutput({tag, "_readyNotBusy"}, 32'({tx_ready, busy}), 32'b10);
    checkOutput({tag, "_noDone"}, 32'({sawDone, tx_done}), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_timeoutPulse"}, 32'(tx_timeout), 32'd0);
  endtask

  initial begin
    logic sawPulse;
    rst        = 1'b1;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    devClkLow  = 1'b0;
    devDataLow = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    checkOutput("reset_ready", 32'(tx_ready), 32'd1);
    checkOutput("reset_flags", 32'({busy, tx_done, tx_ack_err, tx_timeout}), 32'd0);
    rst = 1'b0;

    $display("[TB] send 0xED with ACK");
    sbQ.push_back('{frame: expFrame(8'hED), ackErr: 1'b0});
    applyStimulus("ed", 8'hED, 1'b0);
    deviceClock(11, 1'b1);
    waitDone("ed");

    $display("[TB] send 0xFF without ACK");
    sbQ.push_back('{frame: expFrame(8'hFF), ackErr: 1'b1});
    applyStimulus("ff", 8'hFF, 1'b0);
    deviceClock(11, 1'b0);
    waitDone("ff");

    $display("[TB] send 0x5A while requesting 0xAA during the transfer");
    sbQ.push_back('{frame: expFrame(8'h5A), ackErr: 1'b0});
    applyStimulus("hold", 8'h5A, 1'b1);
    deviceClock(11, 1'b1);
    waitDone("hold");
    @(negedge clk);
    checkOutput("hold_noReaccept", 32'(busy), 32'd0);

    $display("[TB] send 0x01, device never clocks");
    applyStimulus("sto", 8'h01, 1'b0);
    waitTimeout("sto", STO);

    $display("[TB] send 0x3C, device stops after edge 4");
    applyStimulus("pto", 8'h3C, 1'b0);
    deviceClock(4, 1'b0);
    waitTimeout("pto", -1);

    $display("[TB] reset during BITS, then send 0x00");
    applyStimulus("rstmid", 8'h96, 1'b0);
    deviceClock(5, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    checkOutput("rstmid_readyBusy", 32'({tx_ready, busy}), 32'b10);
    checkOutput("rstmid_pulses", 32'({tx_done, tx_timeout}), 32'd0);
    rst = 1'b0;
    sawPulse = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (tx_done || tx_timeout) sawPulse = 1'b1;
    end
    checkOutput("rstmid_quiet", 32'(sawPulse), 32'd0);
    sbQ.push_back('{frame: expFrame(8'h00), ackErr: 1'b0});
    applyStimulus("zero", 8'h00, 1'b0);
    deviceClock(11, 1'b1);
    waitDone("zero");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
